// File: rtl/mem_port_arbiter.sv
// Shares one memory slave port between the instruction-fetch master and the data master.
// Requests are arbitrated round-robin, and the selection is held while a request waits for
// grant. The owner of each accepted transaction is queued in an ID FIFO so that in-order
// slave responses are routed back to the master that issued them.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata          instruction-fetch master (read only)
//   d_req/d_we/d_be/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata   data master
//   m_req/m_we/m_be/m_addr/m_wdata <- m_gnt/m_rvalid/m_rdata   memory slave
//   o_resp_err                          sticky: slave response seen with nothing outstanding
module mem_port_arbiter #(
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   // instruction-fetch master
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   // data master
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   // memory slave
   output logic                m_req,
   output logic                m_we,
   output logic [DATA_W/8-1:0] m_be,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_gnt,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                o_resp_err
);

   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic {OwnInstr = 1'b0, OwnData = 1'b1} owner_e;
   typedef enum logic {ArbIdle = 1'b0, ArbWait = 1'b1} arb_state_e;

   arb_state_e                 state_q, state_d;
   owner_e                     sel_q, sel_d;
   owner_e                     last_owner_q;
   owner_e                     sel;
   owner_e                     head;
   logic [MAX_OUTSTANDING-1:0] owner_fifo_q;
   logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       resp_err_q;
   logic                       full, push, pop;

   assign full = (count_q == FULL_CNT);

   // Arbitration and the request mux onto the slave port.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      sel     = sel_q;
      m_req   = 1'b0;
      unique case (state_q)
         ArbIdle: begin
            if (!full && (i_req || d_req)) begin
               m_req = 1'b1;
               if (i_req && d_req) begin
                  sel = (last_owner_q == OwnInstr) ? OwnData : OwnInstr;
               end else begin
                  sel = d_req ? OwnData : OwnInstr;
               end
               if (!m_gnt) begin
                  state_d = ArbWait;
                  sel_d   = sel;
               end
            end
         end
         ArbWait: begin
            // Selection is frozen until the slave accepts, whatever the other master does.
            m_req = 1'b1;
            sel   = sel_q;
            if (m_gnt) begin
               state_d = ArbIdle;
            end
         end
         default: state_d = ArbIdle;
      endcase

      m_we    = 1'b0;
      m_be    = '0;
      m_addr  = '0;
      m_wdata = '0;
      if (m_req) begin
         if (sel == OwnData) begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
         end else begin
            m_be   = '1;
            m_addr = i_addr;
         end
      end
   end

   assign push  = m_req & m_gnt;
   assign i_gnt = push & (sel == OwnInstr);
   assign d_gnt = push & (sel == OwnData);

   // Responses arrive in order, so the FIFO head always names the owner.
   assign pop      = m_rvalid & (count_q != '0);
   assign head     = owner_e'(owner_fifo_q[rd_ptr_q]);
   assign i_rvalid = pop & (head == OwnInstr);
   assign d_rvalid = pop & (head == OwnData);
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

   assign o_resp_err = resp_err_q;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ArbIdle;
         sel_q        <= OwnInstr;
         last_owner_q <= OwnInstr;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         count_q <= count_d;
         if (push) begin
            wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
            last_owner_q <= sel;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (m_rvalid && (count_q == '0)) begin
            resp_err_q <= 1'b1;
         end
      end
   end

   // Owner storage needs no reset: entries are only read behind a nonzero count.
   always_ff @(posedge clk) begin
      if (push) begin
         owner_fifo_q[wr_ptr_q] <= sel;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized
// master/slave traffic, all checked every cycle against a transaction-level reference model
// (owner queue, last owner, pending held selection, sticky error flag).
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MAX_OUT = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_req, i_gnt, i_rvalid;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req, d_we, d_gnt, d_rvalid;
   logic [3:0]        d_be;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata, d_rdata;
   logic              m_req, m_we, m_gnt, m_rvalid;
   logic [3:0]        m_be;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_rdata;
   logic              o_resp_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .MAX_OUTSTANDING(MAX_OUT)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .o_resp_err(o_resp_err)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state: 0 = instruction master, 1 = data master.
   bit mdl_owners[$];
   bit mdl_last     = 1'b0;
   bit mdl_held     = 1'b0;
   bit mdl_held_sel = 1'b0;
   bit mdl_err      = 1'b0;

   // Last-cycle handshakes, for the random master/slave drivers.
   bit last_i_gnt = 1'b0;
   bit last_d_gnt = 1'b0;
   bit last_hs    = 1'b0;
   int rsp_times[$];
   int last_time  = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Called just after a falling edge with this cycle's inputs set; checks outputs,
   // advances the model across the rising edge, and returns at the next falling edge.
   task automatic step();
      bit req_out, sel, hs, pop, head;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      logic [3:0]        e_be;
      bit                e_we;
      #1;
      if (mdl_held) begin
         req_out = 1'b1;
         sel     = mdl_held_sel;
      end else if (mdl_owners.size() < MAX_OUT && (i_req || d_req)) begin
         req_out = 1'b1;
         sel     = (i_req && d_req) ? !mdl_last : d_req;
      end else begin
         req_out = 1'b0;
         sel     = 1'b0;
      end
      hs   = req_out && m_gnt;
      pop  = m_rvalid && (mdl_owners.size() > 0);
      head = pop ? mdl_owners[0] : 1'b0;
      e_addr  = !req_out ? '0 : (sel ? d_addr : i_addr);
      e_we    = req_out && sel && d_we;
      e_be    = !req_out ? 4'h0 : (sel ? d_be : 4'hF);
      e_wdata = (req_out && sel) ? d_wdata : '0;

      check_eq("m_req", 64'(m_req), 64'(req_out));
      check_eq("m_addr", 64'(m_addr), 64'(e_addr));
      check_eq("m_we", 64'(m_we), 64'(e_we));
      check_eq("m_be", 64'(m_be), 64'(e_be));
      check_eq("m_wdata", 64'(m_wdata), 64'(e_wdata));
      check_eq("i_gnt", 64'(i_gnt), 64'(hs && !sel));
      check_eq("d_gnt", 64'(d_gnt), 64'(hs && sel));
      check_eq("i_rvalid", 64'(i_rvalid), 64'(pop && !head));
      check_eq("d_rvalid", 64'(d_rvalid), 64'(pop && head));
      check_eq("i_rdata", 64'(i_rdata), 64'(m_rdata));
      check_eq("d_rdata", 64'(d_rdata), 64'(m_rdata));
      check_eq("resp_err", 64'(o_resp_err), 64'(mdl_err));

      last_i_gnt = hs && !sel;
      last_d_gnt = hs && sel;
      last_hs    = hs && rst_n;

      @(posedge clk);
      if (!rst_n) begin
         mdl_owners.delete();
         mdl_last = 1'b0;
         mdl_held = 1'b0;
         mdl_err  = 1'b0;
      end else begin
         if (m_rvalid && !pop) mdl_err = 1'b1;
         if (pop) void'(mdl_owners.pop_front());
         if (hs) begin
            mdl_owners.push_back(sel);
            mdl_last = sel;
         end
         mdl_held     = req_out && !m_gnt;
         mdl_held_sel = sel;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      i_req = 0; i_addr = '0;
      d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
      m_gnt = 0; m_rvalid = 0; m_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      step();
      rst_n = 1;
   endtask

   task automatic drive_random();
      if (!rst_n) begin
         rsp_times.delete();
         last_time = 0;
         rst_n = 1;
      end
      if (i_req && last_i_gnt) i_req = 0;
      if (!i_req && ($urandom % 3 == 0)) begin
         i_req  = 1;
         i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (d_req && last_d_gnt) d_req = 0;
      if (!d_req && ($urandom % 3 == 0)) begin
         d_req   = 1;
         d_we    = $urandom_range(0, 1) == 1;
         d_be    = 4'($urandom_range(0, 15));
         d_addr  = $urandom;
         d_wdata = $urandom;
      end
      if (last_hs) begin
         int t;
         t = cyc + $urandom_range(0, 2);
         if (t <= last_time) t = last_time + 1;
         last_time = t;
         rsp_times.push_back(t);
      end
      m_rvalid = 0;
      if (rsp_times.size() > 0 && rsp_times[0] <= cyc) begin
         void'(rsp_times.pop_front());
         m_rvalid = 1;
      end
      m_rdata = $urandom;
      m_gnt   = ($urandom % 4) != 0;
      if ($urandom % 250 == 0) rst_n = 0;
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      @(negedge clk);
      do_reset();
      do_reset();
      step();  // idle after reset: everything low

      // Single fetch, granted at once, answered next cycle.
      do_reset();
      i_req = 1; i_addr = 32'h10; m_gnt = 1;
      step();
      i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0000_0013;
      step();
      m_rvalid = 0;
      step();

      // Contention: grants alternate starting with data, responses follow in order.
      do_reset();
      i_req = 1; i_addr = 32'h44; d_req = 1; d_addr = 32'h100; d_we = 1; d_be = 4'hF;
      d_wdata = 32'hCAFE_F00D; m_gnt = 1;
      for (int k = 0; k < 8; k++) begin
         m_rvalid = (k > 0);
         m_rdata  = 32'h1000 + k;
         step();
      end
      clear_inputs();
      m_rvalid = 1;
      step();
      m_rvalid = 0;

      // Stall hold: data held through three refused cycles while fetch arrives.
      do_reset();
      d_req = 1; d_addr = 32'h200; d_wdata = 32'h55; d_be = 4'h3; d_we = 1;
      step();
      i_req = 1; i_addr = 32'h40;
      step();
      step();
      m_gnt = 1;
      step();
      d_req = 0;
      step();
      i_req = 0; m_gnt = 0; m_rvalid = 1;
      step();
      step();
      m_rvalid = 0;

      // FIFO full: fifth request refused until a response frees a slot.
      do_reset();
      i_req = 1; m_gnt = 1;
      for (int k = 0; k < 4; k++) begin
         i_addr = 32'h80 + 4 * k;
         step();
      end
      i_addr = 32'h90;
      step();
      m_rvalid = 1; m_rdata = 32'hABCD;
      step();
      m_rvalid = 0;
      step();
      i_req = 0; m_gnt = 0; m_rvalid = 1;
      for (int k = 0; k < 4; k++) step();
      m_rvalid = 0;

      // Spurious response sets the sticky error until reset.
      do_reset();
      m_rvalid = 1;
      step();
      m_rvalid = 0;
      step();
      step();
      do_reset();
      step();

      // Reset mid-operation while waiting for grant.
      do_reset();
      i_req = 1; i_addr = 32'h300; m_gnt = 1;
      step();
      step();
      i_req = 0; d_req = 1; d_addr = 32'h400; m_gnt = 0;
      step();
      rst_n = 0;
      step();
      rst_n = 1;
      i_req = 1; m_gnt = 1;
      step();
      step();

      // Randomized traffic.
      do_reset();
      last_i_gnt = 0; last_d_gnt = 0; last_hs = 0;
      rsp_times.delete();
      last_time = 0;
      for (int k = 0; k < 3000; k++) begin
         drive_random();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
